// File: rtl/wb_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_result_stage
// Purpose  : Registered, handshaked writeback stage for an RV32I core.
//            - Selects the writeback value from one of four sources: ALU
//              result, load data, PC+4 or the U-type immediate.
//            - Waits for the memory read response on loads.
//            - Aligns and extends sub-word loads.
//            - Flags misaligned loads.
//            - Drives the register-file write port.
// Ports    :
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   in_valid_i     writeback request present
//   in_ready_o     stage can accept a request this cycle
//   result_src_i   00 ALU, 01 load, 10 PC+4, 11 U-immediate
//   alu_result_i   ALU output
//   pc_plus4_i     PC+4
//   imm_u_i        U-type immediate
//   funct3_i       load width/sign (LB/LH/LW/LBU/LHU)
//   addr_lo_i      load byte address [1:0]
//   rd_i           destination register
//   reg_write_i    instruction writes rd
//   mem_rvalid_i   memory read data valid (only sampled while waiting)
//   mem_rdata_i    raw aligned-word read data
//   rf_we_o        register-file write enable
//   rf_waddr_o     register-file write address
//   rf_wdata_o     register-file write data
//   misalign_err_o one-cycle misaligned-load pulse
//   busy_o         waiting on a memory response
// Revision : 1.0 - initial release
// ============================================================================
module wb_result_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [1:0]        result_src_i,
  input  logic [XLEN-1:0]   alu_result_i,
  input  logic [XLEN-1:0]   pc_plus4_i,
  input  logic [XLEN-1:0]   imm_u_i,
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic              reg_write_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              rf_we_o,
  output logic [REG_AW-1:0] rf_waddr_o,
  output logic [XLEN-1:0]   rf_wdata_o,
  output logic              misalign_err_o,
  output logic              busy_o
);

  localparam logic [1:0] c_src_alu  = 2'b00;
  localparam logic [1:0] c_src_load = 2'b01;
  localparam logic [1:0] c_src_pc4  = 2'b10;

  localparam logic [2:0] c_f3_lb  = 3'b000;
  localparam logic [2:0] c_f3_lh  = 3'b001;
  localparam logic [2:0] c_f3_lbu = 3'b100;
  localparam logic [2:0] c_f3_lhu = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_WRITE    = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                rf_we_q, rf_we_d;
  logic [REG_AW-1:0]   rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]     rf_wdata_q, rf_wdata_d;
  logic                misalign_q, misalign_d;

  // Load context captured at acceptance, used when the response arrives.
  logic [2:0]          ld_funct3_q, ld_funct3_d;
  logic [1:0]          ld_addr_q, ld_addr_d;
  logic [REG_AW-1:0]   ld_rd_q, ld_rd_d;
  logic                ld_rw_q, ld_rw_d;

  logic                w_is_load;
  logic                w_misalign;
  logic [XLEN-1:0]     w_src_val;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [XLEN-1:0]     w_word_ext;
  logic [XLEN-1:0]     w_load_data;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  assign w_is_load = (result_src_i == c_src_load);

  // Byte loads can never be misaligned; halfwords need an even address;
  // words (including the undefined encodings treated as LW) need addr 00.
  always_comb begin
    w_misalign = 1'b0;
    if (w_is_load) begin
      case (funct3_i)
        c_f3_lb, c_f3_lbu: w_misalign = 1'b0;
        c_f3_lh, c_f3_lhu: w_misalign = addr_lo_i[0];
        default:           w_misalign = (addr_lo_i != 2'b00);
      endcase
    end
  end

  always_comb begin
    case (result_src_i)
      c_src_alu: w_src_val = alu_result_i;
      c_src_pc4: w_src_val = pc_plus4_i;
      default:   w_src_val = imm_u_i;   // 11; the load value never comes from here
    endcase
  end

  // --------------------------------------------------------------------------
  // Load extraction from the raw aligned word
  // --------------------------------------------------------------------------
  assign w_byte = mem_rdata_i[{ld_addr_q, 3'b000} +: 8];
  assign w_half = mem_rdata_i[{ld_addr_q[1], 4'b0000} +: 16];

  // A zero-width replication is not legal, so the full-word extension only
  // exists when the datapath is wider than the memory word.
  generate
    if (XLEN > 32) begin : g_word_wide
      assign w_word_ext = {{(XLEN-32){mem_rdata_i[31]}}, mem_rdata_i};
    end else begin : g_word_narrow
      assign w_word_ext = mem_rdata_i;
    end
  endgenerate

  always_comb begin
    case (ld_funct3_q)
      c_f3_lb:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      c_f3_lh:  w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
      c_f3_lbu: w_load_data = {{(XLEN-8){1'b0}}, w_byte};
      c_f3_lhu: w_load_data = {{(XLEN-16){1'b0}}, w_half};
      default:  w_load_data = w_word_ext;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    misalign_d  = 1'b0;
    ld_funct3_d = ld_funct3_q;
    ld_addr_d   = ld_addr_q;
    ld_rd_d     = ld_rd_q;
    ld_rw_d     = ld_rw_q;

    case (state_q)
      S_WAIT_MEM: begin
        if (mem_rvalid_i) begin
          state_d    = S_WRITE;
          rf_we_d    = ld_rw_q && (ld_rd_q != '0);
          rf_waddr_d = ld_rd_q;
          rf_wdata_d = w_load_data;
        end
      end

      // IDLE and WRITE both accept; WRITE falls back to IDLE when nothing
      // new arrives. The unused encoding behaves as IDLE.
      default: begin
        state_d = S_IDLE;
        if (in_valid_i) begin
          if (!w_is_load) begin
            state_d    = S_WRITE;
            rf_we_d    = reg_write_i && (rd_i != '0);
            rf_waddr_d = rd_i;
            rf_wdata_d = w_src_val;
          end else if (w_misalign) begin
            misalign_d = 1'b1;
          end else begin
            state_d     = S_WAIT_MEM;
            ld_funct3_d = funct3_i;
            ld_addr_d   = addr_lo_i;
            ld_rd_d     = rd_i;
            ld_rw_d     = reg_write_i;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      misalign_q  <= 1'b0;
      ld_funct3_q <= 3'b000;
      ld_addr_q   <= 2'b00;
      ld_rd_q     <= '0;
      ld_rw_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      misalign_q  <= misalign_d;
      ld_funct3_q <= ld_funct3_d;
      ld_addr_q   <= ld_addr_d;
      ld_rd_q     <= ld_rd_d;
      ld_rw_q     <= ld_rw_d;
    end
  end

  assign in_ready_o     = (state_q != S_WAIT_MEM);
  assign busy_o         = (state_q == S_WAIT_MEM);
  assign rf_we_o        = rf_we_q;
  assign rf_waddr_o     = rf_waddr_q;
  assign rf_wdata_o     = rf_wdata_q;
  assign misalign_err_o = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_result_stage
// Purpose  : Self-checking bench for wb_result_stage.
//            - Directed scenarios, followed by randomized transactions.
//            - Expected values come from a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_result_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  result_src = 2'b00;
  logic [31:0] alu_result = '0;
  logic [31:0] pc_plus4 = '0;
  logic [31:0] imm_u = '0;
  logic [2:0]  funct3 = 3'b000;
  logic [1:0]  addr_lo = 2'b00;
  logic [4:0]  rd = '0;
  logic        reg_write = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        misalign_err;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // Last written-back address/data, valid once a write has completed.
  logic [4:0]  last_waddr = '0;
  logic [31:0] last_wdata = '0;
  logic        hold_known = 1'b1;

  wb_result_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .result_src_i   (result_src),
    .alu_result_i   (alu_result),
    .pc_plus4_i     (pc_plus4),
    .imm_u_i        (imm_u),
    .funct3_i       (funct3),
    .addr_lo_i      (addr_lo),
    .rd_i           (rd),
    .reg_write_i    (reg_write),
    .mem_rvalid_i   (mem_rvalid),
    .mem_rdata_i    (mem_rdata),
    .rf_we_o        (rf_we),
    .rf_waddr_o     (rf_waddr),
    .rf_wdata_o     (rf_wdata),
    .misalign_err_o (misalign_err),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: load value from the rules of RV32I load extraction.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] d);
    int unsigned ai;
    int unsigned b;
    int unsigned h;
    ai = a;
    b  = (d >> (8 * ai)) & 32'hFF;
    h  = (d >> (16 * (ai / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return d;
    endcase
  endfunction

  function automatic logic ref_misalign(input logic [2:0] f3, input logic [1:0] a);
    int unsigned ai;
    ai = a;
    if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
    if (f3 == 3'd1 || f3 == 3'd5) return (ai % 2) != 0;
    return ai != 0;
  endfunction

  // One transaction presented on the cycle after the previous one.
  // nbusy = number of WAIT_MEM cycles (the last of which carries mem_rvalid).
  task automatic txn(input logic [1:0] src, input logic [31:0] val, input logic [2:0] f3,
                     input logic [1:0] a, input logic [4:0] rdv, input logic rw,
                     input int nbusy, input logic [31:0] rdata, input logic rv_acc,
                     input logic stall);
    logic        exp_we;
    logic [31:0] exp_data;
    exp_we = rw && (rdv != 5'd0);

    alu_result = $urandom;
    pc_plus4   = $urandom;
    imm_u      = $urandom;
    case (src)
      2'b00:   alu_result = val;
      2'b10:   pc_plus4   = val;
      2'b11:   imm_u      = val;
      default: ;
    endcase
    result_src = src;
    funct3     = f3;
    addr_lo    = a;
    rd         = rdv;
    reg_write  = rw;
    in_valid   = 1'b1;
    mem_rvalid = rv_acc;
    mem_rdata  = $urandom;
    check("accept_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid   = 1'b0;
    mem_rvalid = 1'b0;

    if (src != 2'b01) begin
      check("nl_we", {31'd0, rf_we}, {31'd0, exp_we});
      check("nl_waddr", {27'd0, rf_waddr}, {27'd0, rdv});
      check("nl_wdata", rf_wdata, val);
      check("nl_busy", {31'd0, busy}, 32'd0);
      last_waddr = rdv;
      last_wdata = val;
      hold_known = 1'b1;
    end else if (ref_misalign(f3, a)) begin
      check("mis_err", {31'd0, misalign_err}, 32'd1);
      check("mis_we", {31'd0, rf_we}, 32'd0);
      check("mis_busy", {31'd0, busy}, 32'd0);
      check("mis_ready", {31'd0, in_ready}, 32'd1);
      hold_known = 1'b0;
    end else begin
      for (int k = 0; k < nbusy; k++) begin
        check("ld_busy", {31'd0, busy}, 32'd1);
        check("ld_ready", {31'd0, in_ready}, 32'd0);
        check("ld_we_wait", {31'd0, rf_we}, 32'd0);
        if (k == nbusy - 1) begin
          in_valid   = 1'b0;
          mem_rvalid = 1'b1;
          mem_rdata  = rdata;
        end else begin
          // Competing request while stalled must not be taken.
          in_valid   = stall;
          result_src = 2'b00;
          alu_result = $urandom;
          rd         = 5'd9;
          reg_write  = 1'b1;
          mem_rvalid = 1'b0;
          mem_rdata  = $urandom;
        end
        step();
      end
      in_valid   = 1'b0;
      mem_rvalid = 1'b0;
      exp_data   = ref_load(f3, a, rdata);
      check("ld_we", {31'd0, rf_we}, {31'd0, exp_we});
      check("ld_waddr", {27'd0, rf_waddr}, {27'd0, rdv});
      check("ld_wdata", rf_wdata, exp_data);
      check("ld_busy_end", {31'd0, busy}, 32'd0);
      last_waddr = rdv;
      last_wdata = exp_data;
      hold_known = 1'b1;
    end
  endtask

  // Cycle with no request; optionally a stray mem_rvalid that must be ignored.
  task automatic idle(input logic rv);
    in_valid   = 1'b0;
    mem_rvalid = rv;
    mem_rdata  = $urandom;
    step();
    mem_rvalid = 1'b0;
    check("idle_we", {31'd0, rf_we}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_ready", {31'd0, in_ready}, 32'd1);
    check("idle_mis", {31'd0, misalign_err}, 32'd0);
    if (hold_known) begin
      check("idle_hold_addr", {27'd0, rf_waddr}, {27'd0, last_waddr});
      check("idle_hold_data", rf_wdata, last_wdata);
    end
  endtask

  initial begin
    // Reset values
    step();
    step();
    check("rst_we", {31'd0, rf_we}, 32'd0);
    check("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    check("rst_mis", {31'd0, misalign_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;

    // ALU path, then an idle cycle
    txn(2'b00, 32'h0000_1234, 3'd0, 2'd0, 5'd5, 1'b1, 1, 32'd0, 1'b0, 1'b0);
    idle(1'b0);

    // Back-to-back PC+4 then U-immediate
    txn(2'b10, 32'h0000_0104, 3'd0, 2'd0, 5'd1, 1'b1, 1, 32'd0, 1'b0, 1'b0);
    txn(2'b11, 32'hABCD_E000, 3'd0, 2'd0, 5'd2, 1'b1, 1, 32'd0, 1'b0, 1'b0);
    idle(1'b0);

    // Load extension cases
    txn(2'b01, 32'd0, 3'd0, 2'd3, 5'd3, 1'b1, 3, 32'h80FF_7F01, 1'b0, 1'b0);
    txn(2'b01, 32'd0, 3'd5, 2'd2, 5'd4, 1'b1, 1, 32'h80FF_7F01, 1'b0, 1'b0);
    txn(2'b01, 32'd0, 3'd1, 2'd0, 5'd6, 1'b1, 2, 32'h80FF_7F01, 1'b0, 1'b0);
    idle(1'b0);

    // Misaligned LW
    txn(2'b01, 32'd0, 3'd2, 2'd1, 5'd7, 1'b1, 1, 32'd0, 1'b0, 1'b0);
    idle(1'b0);

    // LW to x0 with a stalled competing request, then a stray rvalid in IDLE
    txn(2'b01, 32'd0, 3'd2, 2'd0, 5'd0, 1'b1, 2, 32'h1357_9BDF, 1'b1, 1'b1);
    idle(1'b1);

    // Reset mid-load, then the aborted load's response
    result_src = 2'b01;
    funct3     = 3'd2;
    addr_lo    = 2'd0;
    rd         = 5'd8;
    reg_write  = 1'b1;
    in_valid   = 1'b1;
    step();
    in_valid = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_rst_busy", {31'd0, busy}, 32'd0);
    check("abort_rst_wdata", rf_wdata, 32'd0);
    last_waddr = '0;
    last_wdata = '0;
    hold_known = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    step();
    mem_rvalid = 1'b0;
    check("abort_we", {31'd0, rf_we}, 32'd0);
    check("abort_waddr", {27'd0, rf_waddr}, 32'd0);
    check("abort_wdata", rf_wdata, 32'd0);
    check("abort_busy2", {31'd0, busy}, 32'd0);
    check("abort_mis", {31'd0, misalign_err}, 32'd0);

    // Randomized transactions against the reference model
    for (int i = 0; i < 150; i++) begin
      logic [1:0] s;
      s = 2'($urandom_range(0, 3));
      txn(s, $urandom, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
          5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
          int'($urandom_range(1, 4)), $urandom, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle(1'($urandom_range(0, 1)));
    end
    idle(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
